// File: rtl/instr_loader.sv
// Boot-time instruction RAM writer: takes a length-prefixed byte stream, assembles
// big-endian words, writes them into instruction memory and holds the CPU until a checksum match.
module instr_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHK    = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
  localparam logic [15:0]       MAX_N     = 16'(MAX_WORDS);

  state_t              state_r;
  state_t              state_nxt_s;
  logic                start_en_r;
  logic [15:0]         len_r;
  logic [15:0]         len_full_s;
  logic [15:0]         word_cnt_r;
  logic [1:0]          byte_idx_r;
  logic [7:0]          chk_r;
  logic                accept_s;
  logic                start_go_s;
  logic                in_ready_r;
  logic                wr_en_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [31:0]         wr_data_r;
  logic                cpu_hold_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;

  function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  function automatic logic rx_state(input state_t st);
    case (st)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic busy_state(input state_t st);
    case (st)
      S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHK: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  assign accept_s   = in_valid & in_ready_r;
  // start_en_r masks the first edge after reset release, so a coincident start is dropped
  assign start_go_s = start & start_en_r;
  assign len_full_s = {len_r[15:8], in_data};

  // State register and the post-reset start qualifier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      start_en_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      start_en_r <= 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_go_s) begin
          state_nxt_s = S_LEN_HI;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_LEN_HI: begin
        if (accept_s) begin
          state_nxt_s = S_LEN_LO;
        end else begin
          state_nxt_s = S_LEN_HI;
        end
      end
      S_LEN_LO: begin
        if (!accept_s) begin
          state_nxt_s = S_LEN_LO;
        end else if (len_full_s > MAX_N) begin
          state_nxt_s = S_ERR;
        end else if (len_full_s == 16'd0) begin
          state_nxt_s = S_CHK;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_DATA: begin
        if (accept_s && (byte_idx_r == 2'd3)) begin
          state_nxt_s = S_WRITE;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_WRITE: begin
        if ((word_cnt_r + 16'd1) == len_r) begin
          state_nxt_s = S_CHK;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_CHK: begin
        if (!accept_s) begin
          state_nxt_s = S_CHK;
        end else if (chk_r == in_data) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_ERR;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Length capture, word assembly, checksum and address/count stepping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_r      <= 16'd0;
      word_cnt_r <= 16'd0;
      byte_idx_r <= 2'd0;
      chk_r      <= 8'd0;
      wr_addr_r  <= BASE_A;
      wr_data_r  <= 32'd0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_go_s) begin
            len_r      <= 16'd0;
            word_cnt_r <= 16'd0;
            byte_idx_r <= 2'd0;
            chk_r      <= 8'd0;
            wr_addr_r  <= BASE_A;
          end
        end
        S_LEN_HI: begin
          if (accept_s) len_r[15:8] <= in_data;
        end
        S_LEN_LO: begin
          if (accept_s) len_r[7:0] <= in_data;
        end
        S_DATA: begin
          if (accept_s) begin
            wr_data_r  <= {wr_data_r[23:0], in_data};
            chk_r      <= chk_next(chk_r, in_data);
            byte_idx_r <= byte_idx_r + 2'd1;
          end
        end
        S_WRITE: begin
          // address wraps naturally at 2^ADDR_W
          wr_addr_r  <= wr_addr_r + ADDR_STEP;
          word_cnt_r <= word_cnt_r + 16'd1;
        end
        default: begin
          word_cnt_r <= word_cnt_r;
        end
      endcase
    end
  end

  // Outputs registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_r <= 1'b0;
      wr_en_r    <= 1'b0;
      cpu_hold_r <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      in_ready_r <= rx_state(state_nxt_s);
      wr_en_r    <= (state_nxt_s == S_WRITE);
      cpu_hold_r <= (state_nxt_s != S_DONE);
      busy_r     <= busy_state(state_nxt_s);
      done_r     <= (state_nxt_s == S_DONE);
      err_r      <= (state_nxt_s == S_ERR);
    end
  end

  assign in_ready = in_ready_r;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign cpu_hold = cpu_hold_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a per-cycle vector table for a nominal load and reload,
// followed by hand-written sequences for backpressure, checksum/length errors and mid-load reset.
module tb_instr_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  instr_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        start;
    logic        vld;
    logic [7:0]  d;
    logic [47:0] exp;
  } vec_t;

  vec_t        tbl [17];
  int          n_vec = 0;
  int          n_miss = 0;
  int          rdy_viol = 0;
  logic [41:0] wr_log [$];
  logic [31:0] img_q [$];

  function automatic logic [47:0] pack(input logic rdy, input logic wr, input logic [9:0] a,
                                       input logic [31:0] w, input logic h, input logic b,
                                       input logic dn, input logic e);
    return {rdy, wr, a, w, h, b, dn, e};
  endfunction

  function automatic logic [47:0] dut_outs();
    return pack(in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err);
  endfunction

  function automatic logic [41:0] log_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    else return '1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // record every instruction-memory write
  always @(negedge clk) begin
    if (rst && wr_en) begin
      wr_log.push_back({wr_addr, wr_data});
      if (in_ready) rdy_viol++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    if (gap) begin
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk);
    end
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = b;
      ok = in_ready;
      @(posedge clk);
    end
    #1; in_valid = 1'b0;
    if (!ok) begin
      n_vec++; n_miss++;
      $display("FAIL byte_timeout: byte %02h not accepted within 50 cycles", b);
    end
  endtask

  task automatic load_img(input logic [15:0] n, input logic [7:0] c, input bit gap);
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
    for (int i = 0; i < img_q.size(); i++) begin
      for (int k = 3; k >= 0; k--) send_byte(img_q[i][8*k +: 8], gap);
    end
    send_byte(c, gap);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // nominal N=2 load: 20080005, AC080004, checksum 0x8D, then a reload start
    tbl[0]  = '{1'b0, 1'b0, 8'h00, pack(1'b0, 1'b0, 10'h000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0)};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, pack(1'b1, 1'b0, 10'h000, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[2]  = '{1'b0, 1'b1, 8'h00, pack(1'b1, 1'b0, 10'h000, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[3]  = '{1'b0, 1'b1, 8'h02, pack(1'b1, 1'b0, 10'h000, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[4]  = '{1'b0, 1'b1, 8'h20, pack(1'b1, 1'b0, 10'h000, 32'h00000020, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[5]  = '{1'b0, 1'b1, 8'h08, pack(1'b1, 1'b0, 10'h000, 32'h00002008, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, pack(1'b1, 1'b0, 10'h000, 32'h00200800, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[7]  = '{1'b0, 1'b1, 8'h05, pack(1'b0, 1'b1, 10'h000, 32'h20080005, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, pack(1'b1, 1'b0, 10'h004, 32'h20080005, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[9]  = '{1'b0, 1'b1, 8'hAC, pack(1'b1, 1'b0, 10'h004, 32'h080005AC, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[10] = '{1'b0, 1'b1, 8'h08, pack(1'b1, 1'b0, 10'h004, 32'h0005AC08, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[11] = '{1'b0, 1'b1, 8'h00, pack(1'b1, 1'b0, 10'h004, 32'h05AC0800, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[12] = '{1'b0, 1'b1, 8'h04, pack(1'b0, 1'b1, 10'h004, 32'hAC080004, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[13] = '{1'b0, 1'b0, 8'h00, pack(1'b1, 1'b0, 10'h008, 32'hAC080004, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[14] = '{1'b0, 1'b1, 8'h8D, pack(1'b0, 1'b0, 10'h008, 32'hAC080004, 1'b0, 1'b0, 1'b1, 1'b0)};
    tbl[15] = '{1'b0, 1'b0, 8'h00, pack(1'b0, 1'b0, 10'h008, 32'hAC080004, 1'b0, 1'b0, 1'b1, 1'b0)};
    tbl[16] = '{1'b1, 1'b0, 8'h00, pack(1'b1, 1'b0, 10'h000, 32'hAC080004, 1'b1, 1'b1, 1'b0, 1'b0)};

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'(dut_outs()),
          64'(pack(1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0)));
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      start = tbl[i].start; in_valid = tbl[i].vld; in_data = tbl[i].d;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), 64'(dut_outs()), 64'(tbl[i].exp));
    end
    start = 1'b0; in_valid = 1'b0;

    // reload continues from LEN_HI: N=1, DEADBEEF, checksum 0x22
    wr_log.delete();
    img_q = '{32'hDEADBEEF};
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    for (int k = 3; k >= 0; k--) send_byte(img_q[0][8*k +: 8], 1'b0);
    send_byte(8'h22, 1'b0);
    check("reload_nwr", 64'(wr_log.size()), 64'd1);
    check("reload_wr0", 64'(log_at(0)), 64'({10'h000, 32'hDEADBEEF}));
    check("reload_done", 64'({done, cpu_hold, err}), 64'(3'b100));

    // backpressure: valid low every other cycle
    pulse_start(); wr_log.delete(); rdy_viol = 0;
    img_q = '{32'h20080005, 32'hAC080004};
    load_img(16'd2, 8'h8D, 1'b1);
    check("bp_nwr", 64'(wr_log.size()), 64'd2);
    check("bp_wr0", 64'(log_at(0)), 64'({10'h000, 32'h20080005}));
    check("bp_wr1", 64'(log_at(1)), 64'({10'h004, 32'hAC080004}));
    check("bp_rdy_in_write", 64'(rdy_viol), 64'd0);
    check("bp_done", 64'({done, cpu_hold, err}), 64'(3'b100));

    // same image with checksum off by one bit
    pulse_start(); wr_log.delete();
    load_img(16'd2, 8'h8C, 1'b0);
    check("chk8c_nwr", 64'(wr_log.size()), 64'd2);
    check("chk8c_err", 64'({err, done, cpu_hold}), 64'(3'b101));

    // N=1 word 01234567 (true checksum 0x00) sent with 0x44
    pulse_start(); wr_log.delete();
    img_q = '{32'h01234567};
    load_img(16'd1, 8'h44, 1'b0);
    check("badchk_nwr", 64'(wr_log.size()), 64'd1);
    check("badchk_wr0", 64'(log_at(0)), 64'({10'h000, 32'h01234567}));
    check("badchk_err", 64'({err, done, cpu_hold}), 64'(3'b101));
    pulse_start();
    check("restart_clears_err", 64'({err, busy, in_ready}), 64'(3'b011));

    // N=0 with checksum 0x00
    wr_log.delete();
    img_q.delete();
    load_img(16'd0, 8'h00, 1'b0);
    check("n0_done", 64'({done, err, cpu_hold}), 64'(3'b100));
    check("n0_nwr", 64'(wr_log.size()), 64'd0);

    // N=0x0101 exceeds the limit
    pulse_start(); wr_log.delete();
    send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0);
    check("toolong_err", 64'({err, busy, in_ready, cpu_hold}), 64'(4'b1001));
    repeat (3) @(posedge clk);
    #1;
    check("toolong_nwr", 64'(wr_log.size()), 64'd0);

    // N=256: largest image, words 0..255, checksum 0x00
    pulse_start(); wr_log.delete();
    img_q.delete();
    for (int i = 0; i < 256; i++) img_q.push_back(32'(i));
    load_img(16'd256, 8'h00, 1'b0);
    check("max_nwr", 64'(wr_log.size()), 64'd256);
    check("max_last", 64'(log_at(255)), 64'({10'h3FC, 32'h000000FF}));
    check("max_done", 64'({done, err}), 64'(2'b10));

    // asynchronous reset after two bytes of the first word
    pulse_start(); wr_log.delete();
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0); send_byte(8'h23, 1'b0);
    #3; rst = 1'b0;
    #1;
    check("async_reset", 64'(dut_outs()),
          64'(pack(1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0)));
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("start_at_release_ignored", 64'({busy, in_ready}), 64'(2'b00));
    pulse_start(); wr_log.delete();
    img_q = '{32'hCAFEF00D};
    load_img(16'd1, 8'hC9, 1'b0);
    check("post_reset_nwr", 64'(wr_log.size()), 64'd1);
    check("post_reset_wr0", 64'(log_at(0)), 64'({10'h000, 32'hCAFEF00D}));
    check("post_reset_done", 64'({done, cpu_hold, err}), 64'(3'b100));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
